// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RISC-V pipeline: load-use bubbles,
// taken-branch flushes, data-memory wait freezes, a wait watchdog and a stall counter.
module hazard_ctrl #(
  parameter int reg_width = 5,
  parameter int MAX_WAIT  = 15,
  parameter int CNT_W     = 32
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [reg_width-1:0] id_rs1,
  input  logic [reg_width-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [reg_width-1:0] ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 ifid_clr,
  output logic                 idex_en,
  output logic                 idex_clr,
  output logic                 exmem_en,
  output logic                 memwb_en,
  output logic                 err,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERR     = 2'd2
  } state_t;

  state_t              state_r, next_state_s;
  logic [WAIT_W-1:0]   wait_cnt_r, wait_nxt_s;
  logic                err_r, err_set_s;
  logic [CNT_W-1:0]    stall_cnt_r;
  logic                mem_busy_s, freeze_s, lu_s;

  // A dropped mem_req counts as ready, so only an outstanding request can stall.
  assign mem_busy_s = mem_req & ~mem_ready;
  assign freeze_s   = (state_r == ERR) | mem_busy_s;
  assign lu_s       = ex_mem_read & (ex_rd != {reg_width{1'b0}}) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  // State register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r <= RUN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state, wait counter and watchdog decisions
  always_comb begin
    next_state_s = state_r;
    wait_nxt_s   = wait_cnt_r;
    err_set_s    = 1'b0;
    case (state_r)
      RUN: begin
        if (mem_busy_s) begin
          next_state_s = MEMWAIT;
          wait_nxt_s   = {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
          wait_nxt_s   = {WAIT_W{1'b0}};
        end
      end
      MEMWAIT: begin
        if (!mem_busy_s) begin
          next_state_s = RUN;
          wait_nxt_s   = {WAIT_W{1'b0}};
        end else if (wait_cnt_r == WAIT_W'(MAX_WAIT)) begin
          next_state_s = ERR;
          err_set_s    = 1'b1;
        end else begin
          wait_nxt_s   = wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      ERR: begin
        next_state_s = ERR;
      end
      default: begin
        next_state_s = RUN;
        wait_nxt_s   = {WAIT_W{1'b0}};
      end
    endcase
  end

  // Stage enable/clear decode, priority freeze > branch > load-use > normal
  always_comb begin
    pc_en    = 1'b0;
    ifid_en  = 1'b0;
    ifid_clr = 1'b0;
    idex_en  = 1'b0;
    idex_clr = 1'b0;
    exmem_en = 1'b0;
    memwb_en = 1'b0;
    if (!RSTn || freeze_s) begin
      pc_en = 1'b0;
    end else if (ex_branch_taken) begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      ifid_clr = 1'b1;
      idex_en  = 1'b1;
      idex_clr = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
    end else if (lu_s) begin
      idex_en  = 1'b1;
      idex_clr = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
    end
  end

  // Wait counter, sticky error and wrapping stall counter
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wait_cnt_r  <= {WAIT_W{1'b0}};
      err_r       <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      wait_cnt_r <= wait_nxt_s;
      err_r      <= err_r | err_set_s;
      if (!pc_en) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign err       = err_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: expectations are queued when a step
// is driven and checked against the combinational outputs on the falling edge.
module tb_hazard_ctrl;

  logic        CLK, RSTn;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
  logic        pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, memwb_en, err;
  logic [31:0] stall_cnt;

  hazard_ctrl #(.reg_width(5), .MAX_WAIT(4), .CNT_W(32)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr), .idex_en(idex_en),
    .idex_clr(idex_clr), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .err(err), .stall_cnt(stall_cnt)
  );

  // {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, memwb_en}
  localparam logic [6:0] NORM = 7'b1101011;
  localparam logic [6:0] BR   = 7'b1111111;
  localparam logic [6:0] LU   = 7'b0001111;
  localparam logic [6:0] FRZ  = 7'b0000000;

  typedef struct packed {
    logic [6:0]  en;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_cnt = 32'd0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [6:0] outs();
    return {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, memwb_en};
  endfunction

  task automatic check_now(input string tag, input logic [6:0] e_en, input logic e_err,
                           input logic [31:0] e_cnt);
    checks++;
    assert (outs() === e_en) else begin
      failures++;
      $error("FAIL %s en: got %b want %b", tag, outs(), e_en);
    end
    checks++;
    assert (err === e_err) else begin
      failures++;
      $error("FAIL %s err: got %b want %b", tag, err, e_err);
    end
    checks++;
    assert (stall_cnt === e_cnt) else begin
      failures++;
      $error("FAIL %s stall_cnt: got %0d want %0d", tag, stall_cnt, e_cnt);
    end
  endtask

  // One pipeline cycle: drive after the rising edge, check on the falling edge.
  task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd, input logic ld,
                      input logic br, input logic mreq, input logic mrdy,
                      input logic [6:0] e_en, input logic e_err);
    exp_t e;
    @(posedge CLK);
    #1;
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = rd; ex_mem_read = ld; ex_branch_taken = br; mem_req = mreq; mem_ready = mrdy;
    sb.push_back('{en: e_en, err: e_err, cnt: exp_cnt});
    @(negedge CLK);
    e = sb.pop_front();
    check_now(tag, e.en, e.err, e.cnt);
    if (!e.en[6]) exp_cnt = exp_cnt + 32'd1;
  endtask

  initial begin
    RSTn = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    #3;
    check_now("reset", FRZ, 1'b0, 32'd0);
    #5 RSTn = 1'b1;

    step("idle",        5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0);
    step("lu_rs1",      5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU,   1'b0);
    step("lu_after",    5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0);
    step("lu_rd0",      5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NORM, 1'b0);
    step("lu_nouse",    5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, NORM, 1'b0);
    step("lu_rs2",      5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, LU,   1'b0);
    step("br_lu",       5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, BR,   1'b0);
    for (int i = 0; i < 3; i++)
      step("wait3",     5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ,  1'b0);
    step("wait3_rel",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, NORM, 1'b0);
    step("run_again",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0);
    for (int i = 0; i < 2; i++)
      step("lu_frz",    5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, FRZ,  1'b0);
    step("lu_frz_rel",  5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, LU,   1'b0);
    step("lu_frz_bub",  5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0);
    step("rdy_br_w",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, FRZ,  1'b0);
    step("rdy_br",      5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, BR,   1'b0);
    step("drop_w",      5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ,  1'b0);
    step("drop_req",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0);
    for (int i = 0; i < 5; i++)
      step("wdog_wait", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ,  1'b0);
    step("wdog_err",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ,  1'b1);
    step("err_rdy",     5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, FRZ,  1'b1);
    step("err_br",      5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ,  1'b1);

    // Asynchronous reset in the middle of a cycle clears everything at once.
    @(posedge CLK);
    #2 RSTn = 1'b0;
    #1;
    exp_cnt = 32'd0;
    check_now("mid_reset", FRZ, 1'b0, 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    step("post_rst",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0);
    step("post_lu",     5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, LU,   1'b0);
    step("post_cnt",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
